io_port_controller: RTL and testbench

//   Memory-mapped I/O adapter between the PCSP/memory block's io_in/io_out word port and external devices.

---
 rtl/io_pkg.sv | 10 +
 rtl/io_fifo.sv | 63 ++++++
 rtl/io_port_controller.sv | 97 +++++++++
 tb/tb_io_port_controller.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared constants for the memory-mapped I/O port controller
package io_pkg;

    localparam int          IO_ADDR_W    = 16;
    localparam int          IO_DATA_W    = 16;
    localparam int          IO_IN_DEPTH  = 4;
    localparam int          IO_OUT_DEPTH = 2;
    localparam logic [15:0] IO_PORT_ADDR = 16'd255;

endpackage

// File: rtl/io_fifo.sv
// rtl/io_fifo.sv - show-ahead synchronous FIFO with separate occupancy count
module io_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    assign full     = (cnt == CNT_W'(DEPTH));
    assign empty    = (cnt == '0);
    assign count    = cnt;
    assign pop_data = mem[rd_ptr];

    // Full and empty are registered-state flags, so a push while full is dropped
    // even if a pop happens in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/io_port_controller.sv
// rtl/io_port_controller.sv - memory-mapped I/O port: input/output FIFOs plus address decode and stall
module io_port_controller
    import io_pkg::*;
#(
    parameter int          DATA_W    = IO_DATA_W,
    parameter int          IN_DEPTH  = IO_IN_DEPTH,
    parameter int          OUT_DEPTH = IO_OUT_DEPTH,
    parameter logic [15:0] IO_ADDR   = IO_PORT_ADDR
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [IO_ADDR_W-1:0]          addr,
    input  logic                          mem_write,
    input  logic                          mem_access,
    input  logic [DATA_W-1:0]             cpu_wdata,
    output logic [DATA_W-1:0]             cpu_rdata,
    output logic                          io_stall,
    input  logic [DATA_W-1:0]             ext_in_data,
    input  logic                          ext_in_valid,
    output logic                          ext_in_ready,
    output logic [DATA_W-1:0]             ext_out_data,
    output logic                          ext_out_valid,
    input  logic                          ext_out_ready,
    output logic [$clog2(IN_DEPTH):0]     in_count
);

    logic                           sel;
    logic                           rd_req;
    logic                           wr_req;
    logic                           in_rdy_en;
    logic                           in_push;
    logic                           in_pop;
    logic [DATA_W-1:0]              in_head;
    logic                           in_full;
    logic                           in_empty;
    logic                           out_push;
    logic                           out_pop;
    logic                           out_full;
    logic                           out_empty;
    logic [$clog2(OUT_DEPTH):0]     out_count_unused;

    assign sel    = mem_access && (addr == IO_ADDR);
    assign rd_req = sel && !mem_write;
    assign wr_req = sel && mem_write;

    // Keeps the producer throttled until the first clock after reset release.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            in_rdy_en <= 1'b0;
        end else begin
            in_rdy_en <= 1'b1;
        end
    end

    assign ext_in_ready = in_rdy_en && !in_full;
    assign in_push      = ext_in_valid && ext_in_ready;
    assign in_pop       = rd_req && !in_empty;
    assign cpu_rdata    = in_empty ? '0 : in_head;

    assign out_push      = wr_req && !out_full;
    assign ext_out_valid = !out_empty;
    assign out_pop       = ext_out_valid && ext_out_ready;

    // Stall depends only on decode and registered FIFO flags, never on ext_* handshakes.
    assign io_stall = (rd_req && in_empty) || (wr_req && out_full);

    io_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (IN_DEPTH)
    ) u_in_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (in_push),
        .push_data (ext_in_data),
        .pop       (in_pop),
        .pop_data  (in_head),
        .full      (in_full),
        .empty     (in_empty),
        .count     (in_count)
    );

    io_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (OUT_DEPTH)
    ) u_out_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (out_push),
        .push_data (cpu_wdata),
        .pop       (out_pop),
        .pop_data  (ext_out_data),
        .full      (out_full),
        .empty     (out_empty),
        .count     (out_count_unused)
    );

endmodule

// File: tb/tb_io_port_controller.sv
// tb/tb_io_port_controller.sv - scoreboard bench for io_port_controller
module tb_io_port_controller;

    localparam int IN_D  = 4;
    localparam int OUT_D = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] addr = '0;
    logic        mem_write = 1'b0;
    logic        mem_access = 1'b0;
    logic [15:0] cpu_wdata = '0;
    logic [15:0] cpu_rdata;
    logic        io_stall;
    logic [15:0] ext_in_data = '0;
    logic        ext_in_valid = 1'b0;
    logic        ext_in_ready;
    logic [15:0] ext_out_data;
    logic        ext_out_valid;
    logic        ext_out_ready = 1'b0;
    logic [2:0]  in_count;

    io_port_controller dut (
        .clock         (clock),
        .reset         (reset),
        .addr          (addr),
        .mem_write     (mem_write),
        .mem_access    (mem_access),
        .cpu_wdata     (cpu_wdata),
        .cpu_rdata     (cpu_rdata),
        .io_stall      (io_stall),
        .ext_in_data   (ext_in_data),
        .ext_in_valid  (ext_in_valid),
        .ext_in_ready  (ext_in_ready),
        .ext_out_data  (ext_out_data),
        .ext_out_valid (ext_out_valid),
        .ext_out_ready (ext_out_ready),
        .in_count      (in_count)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: occupancy counters plus expected-data queues.
    int          in_cnt = 0;
    int          out_cnt = 0;
    bit          rdy_m = 0;
    logic [15:0] sb_rd[$];
    logic [15:0] sb_out[$];

    bit          mon_en = 1;
    logic        exp_stall = 0;
    logic        exp_in_ready = 0;
    logic        exp_out_valid = 0;
    int          exp_in_count = 0;
    logic        last_stall = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input logic acc, input logic wr, input logic [15:0] a,
                         input logic [15:0] wd, input logic iv, input logic [15:0] id,
                         input logic ordy);
        bit sel, rd, wq, push_in, pop_in, push_out, pop_out;
        mem_access    = acc;
        mem_write     = wr;
        addr          = a;
        cpu_wdata     = wd;
        ext_in_valid  = iv;
        ext_in_data   = id;
        ext_out_ready = ordy;
        sel = acc && (a == 16'd255);
        rd  = sel && !wr;
        wq  = sel && wr;
        exp_in_count  = in_cnt;
        exp_in_ready  = rdy_m && (in_cnt < IN_D);
        exp_out_valid = (out_cnt > 0);
        exp_stall     = (rd && in_cnt == 0) || (wq && out_cnt == OUT_D);
        push_in  = iv && exp_in_ready;
        pop_in   = rd && (in_cnt > 0);
        push_out = wq && (out_cnt < OUT_D);
        pop_out  = exp_out_valid && ordy;
        if (push_in)  sb_rd.push_back(id);
        if (push_out) sb_out.push_back(wd);
        in_cnt  = in_cnt + int'(push_in) - int'(pop_in);
        out_cnt = out_cnt + int'(push_out) - int'(pop_out);
        rdy_m = 1;
        last_stall = exp_stall;
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset(input int hold);
        reset         = 1'b0;
        mem_access    = 1'b0;
        mem_write     = 1'b0;
        ext_in_valid  = 1'b1;
        ext_out_ready = 1'b0;
        sb_rd.delete();
        sb_out.delete();
        in_cnt = 0;
        out_cnt = 0;
        rdy_m = 0;
        exp_stall = 0;
        exp_in_ready = 0;
        exp_out_valid = 0;
        exp_in_count = 0;
        #1;
        chk("rst_out_valid", ext_out_valid, 1'b0);
        chk("rst_in_ready", ext_in_ready, 1'b0);
        chk("rst_cpu_rdata", cpu_rdata, 16'h0);
        chk("rst_in_count", in_count, 3'd0);
        chk("rst_io_stall", io_stall, 1'b0);
        repeat (hold) @(posedge clock);
        #1;
        reset = 1'b1;
        ext_in_valid = 1'b0;
    endtask

    // Monitor: compares flags every cycle and pops the scoreboards on DUT handshakes.
    always @(negedge clock) begin
        if (mon_en) begin
            logic [15:0] head;
            chk("io_stall", io_stall, exp_stall);
            chk("ext_in_ready", ext_in_ready, exp_in_ready);
            chk("ext_out_valid", ext_out_valid, exp_out_valid);
            chk("in_count", in_count, exp_in_count[2:0]);
            head = 16'h0;
            if (exp_in_count > 0) begin
                if (sb_rd.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL rd_scoreboard: empty queue, expected a word at %0t", $time);
                end else begin
                    head = sb_rd[0];
                end
            end
            chk("cpu_rdata", cpu_rdata, head);
            if (mem_access && addr == 16'd255 && !mem_write && !io_stall && exp_in_count > 0
                && sb_rd.size() > 0)
                void'(sb_rd.pop_front());
            if (ext_out_valid) begin
                if (sb_out.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL ext_out_data: got %0h expected no word at %0t", ext_out_data, $time);
                end else begin
                    chk("ext_out_data", ext_out_data, sb_out[0]);
                    if (ext_out_ready) void'(sb_out.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset with producer valid held high
        apply_reset(3);

        // 2: two external pushes then two reads
        cycle(0, 0, 16'd0, 16'h0, 1, 16'h00A5, 0);
        cycle(0, 0, 16'd0, 16'h0, 1, 16'h00A5, 0);
        cycle(0, 0, 16'd0, 16'h0, 1, 16'h5A00, 0);
        cycle(0, 0, 16'd0, 16'h0, 0, 16'h0, 0);
        cycle(1, 0, 16'd255, 16'h0, 0, 16'h0, 0);
        cycle(1, 0, 16'd255, 16'h0, 0, 16'h0, 0);
        cycle(1, 0, 16'd255, 16'h0, 0, 16'h0, 0);
        cycle(0, 0, 16'd0, 16'h0, 0, 16'h0, 0);

        // 3: read on empty stalls, then a word arrives
        repeat (3) cycle(1, 0, 16'd255, 16'h0, 0, 16'h0, 0);
        cycle(1, 0, 16'd255, 16'h0, 1, 16'h1234, 0);
        cycle(1, 0, 16'd255, 16'h0, 0, 16'h0, 0);
        cycle(0, 0, 16'd0, 16'h0, 0, 16'h0, 0);

        // 4: fill input FIFO, fifth word refused, pop re-opens ready
        for (int i = 0; i < 5; i++)
            cycle(0, 0, 16'd0, 16'h0, 1, 16'h1000 + 16'(i), 0);
        cycle(0, 0, 16'd0, 16'h0, 1, 16'h1005, 0);
        cycle(1, 0, 16'd255, 16'h0, 0, 16'h0, 0);
        cycle(0, 0, 16'd0, 16'h0, 0, 16'h0, 0);
        repeat (4) cycle(1, 0, 16'd255, 16'h0, 0, 16'h0, 0);

        // 5: output writes with consumer stalled, then drain
        cycle(1, 1, 16'd255, 16'h0001, 0, 16'h0, 0);
        cycle(1, 1, 16'd255, 16'h0002, 0, 16'h0, 0);
        cycle(1, 1, 16'd255, 16'h0003, 0, 16'h0, 0);
        cycle(1, 1, 16'd255, 16'h0003, 0, 16'h0, 0);
        for (int k = 0; k < 8; k++) begin
            cycle(1, 1, 16'd255, 16'h0003, 0, 16'h0, 1);
            if (!last_stall) break;
        end
        repeat (4) cycle(0, 0, 16'd0, 16'h0, 0, 16'h0, 1);

        // 6: non-hit accesses, then reset mid-drain
        cycle(1, 1, 16'd254, 16'hBEEF, 0, 16'h0, 1);
        cycle(0, 1, 16'd255, 16'hBEEF, 0, 16'h0, 1);
        cycle(0, 0, 16'd255, 16'h0, 0, 16'h0, 1);
        cycle(1, 0, 16'd254, 16'h0, 1, 16'h7777, 1);
        cycle(1, 1, 16'd255, 16'hAAAA, 0, 16'h0, 0);
        cycle(1, 1, 16'd255, 16'hBBBB, 0, 16'h0, 0);
        cycle(0, 0, 16'd0, 16'h0, 0, 16'h0, 1);
        apply_reset(2);

        // Randomized traffic with an occasional reset
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] a;
            a = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'd255;
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom), a, 16'($urandom),
                  1'($urandom_range(0, 2) != 0), 16'($urandom), 1'($urandom_range(0, 2) != 0));
            if (i == 1500) apply_reset(2);
        end
        repeat (6) cycle(0, 0, 16'd0, 16'h0, 0, 16'h0, 1);

        mon_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
